// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU types and constants.
package alu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
    localparam int ALU_WIDTH = 8;
    localparam logic [31:0] DIV_BY_ZERO_Q = '1;
endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: WIDTH+1-bit trial subtraction; borrow is the sign of the difference.
module div_trial_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] minuend,
    input  logic [WIDTH:0] subtrahend,
    output logic [WIDTH:0] diff,
    output logic           borrow
);
    assign diff   = minuend - subtrahend;
    assign borrow = diff[WIDTH];
endmodule

// File: rtl/alu_div8_seq.sv
// alu_div8_seq: sequential restoring divider, one trial subtraction per clock.
// Define SIGNED_DIV_EN for two's-complement operands with truncation toward zero.
module alu_div8_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             zero,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    div_state_t state, next;
    logic [WIDTH:0] a, sh, diff, a_next;
    logic [WIDTH-1:0] q, m, q_next, q_fin, r_fin;
    logic [CNT_W-1:0] cnt;
    logic borrow, accept, last;
    assign accept = state == IDLE && start;
    assign last   = cnt == CNT_W'(1);
    assign busy   = state == RUN;
    assign done   = state == DONE;
    assign sh     = (a << 1) | (WIDTH + 1)'(q[WIDTH-1]);
    div_trial_sub #(.WIDTH(WIDTH)) u_sub (
        .minuend   (sh),
        .subtrahend({1'b0, m}),
        .diff      (diff),
        .borrow    (borrow)
    );
    assign a_next = borrow ? sh : diff;
    assign q_next = {q[WIDTH-2:0], ~borrow};
`ifdef SIGNED_DIV_EN
    logic sign_n, sign_d, ovf, ovf_fin;
    assign q_fin    = (sign_n ^ sign_d) ? -q_next : q_next;
    assign r_fin    = sign_n ? -a_next[WIDTH-1:0] : a_next[WIDTH-1:0];
    // A positive quotient with its MSB set only arises from -2^(W-1) / -1
    assign ovf_fin  = ~(sign_n ^ sign_d) & q_next[WIDTH-1];
    assign overflow = ovf;
`else
    assign q_fin    = q_next;
    assign r_fin    = a_next[WIDTH-1:0];
    assign overflow = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end
    always_comb begin
        next = state;
        if (accept)                     next = divisor == '0 ? DONE : RUN;
        else if (state == RUN && last)  next = DONE;
        else if (state == DONE)         next = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a           <= '0;
            q           <= '0;
            m           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            zero        <= 1'b0;
`ifdef SIGNED_DIV_EN
            sign_n      <= 1'b0;
            sign_d      <= 1'b0;
            ovf         <= 1'b0;
`endif
        end else if (accept) begin
            a   <= '0;
            cnt <= CNT_W'(WIDTH);
`ifdef SIGNED_DIV_EN
            q      <= dividend[WIDTH-1] ? -dividend : dividend;
            m      <= divisor[WIDTH-1] ? -divisor : divisor;
            sign_n <= dividend[WIDTH-1];
            sign_d <= divisor[WIDTH-1];
`else
            q <= dividend;
            m <= divisor;
`endif
            if (divisor == '0) begin
                quotient    <= DIV_BY_ZERO_Q[WIDTH-1:0];
                remainder   <= dividend;
                div_by_zero <= 1'b1;
                zero        <= 1'b0;
`ifdef SIGNED_DIV_EN
                ovf         <= 1'b0;
`endif
            end
        end else if (state == RUN) begin
            a   <= a_next;
            q   <= q_next;
            cnt <= cnt - 1'b1;
            if (last) begin
                quotient    <= q_fin;
                remainder   <= r_fin;
                div_by_zero <= 1'b0;
                zero        <= q_fin == '0;
`ifdef SIGNED_DIV_EN
                ovf         <= ovf_fin;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_div8_seq.sv
// tb_alu_div8_seq: table vectors, corner sequences and random checks against an arithmetic model.
module tb_alu_div8_seq;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0] dividend = '0, divisor = '0;
    logic busy, done, div_by_zero, zero, overflow;
    logic [7:0] quotient, remainder;
    int total = 0, bad = 0;
    logic [7:0] g_q, g_r, e_q, e_r;
    logic g_z, g_dz, g_ov, e_ov;
    int g_lat, g_busy;

    typedef struct {
        logic [7:0] dd, dv, q, r;
        logic z, dz, ov;
        int lat;
    } vec_t;
    vec_t tbl[6];

    alu_div8_seq dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [7:0] dd, input logic [7:0] dv,
                                  output logic [7:0] q, output logic [7:0] r, output logic ovf);
`ifdef SIGNED_DIV_EN
        int a, b;
        a = int'($signed(dd));
        b = int'($signed(dv));
        ovf = 1'b0;
        if (dv == 0) begin q = 8'hFF; r = dd; end
        else if (a == -128 && b == -1) begin q = 8'h80; r = 8'h00; ovf = 1'b1; end
        else begin q = 8'(a / b); r = 8'(a % b); end
`else
        ovf = 1'b0;
        if (dv == 0) begin q = 8'hFF; r = dd; end
        else begin q = dd / dv; r = dd % dv; end
`endif
    endfunction

    task automatic run_op(input logic [7:0] dd, input logic [7:0] dv);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        g_lat  = 0;
        g_busy = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin g_lat = c; break; end
            if (busy) g_busy++;
            @(posedge clk);
            #1;
        end
        chk("done_seen", 32'(g_lat != 0), 1);
        g_q  = quotient;
        g_r  = remainder;
        g_z  = zero;
        g_dz = div_by_zero;
        g_ov = overflow;
        @(posedge clk);
        #1 chk("done_drop", 32'(done), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [7:0] cq, cr, dd, dv;
`ifdef SIGNED_DIV_EN
        tbl[0] = '{8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, 1'b0, 1'b0, 9};
        tbl[1] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 9};
        tbl[2] = '{8'd100, 8'd7, 8'd14, 8'd2,  1'b0, 1'b0, 1'b0, 9};
        tbl[3] = '{8'd42, 8'd0,  8'hFF, 8'd42, 1'b0, 1'b1, 1'b0, 1};
        tbl[4] = '{8'd7,  8'hFE, 8'hFD, 8'd1,  1'b0, 1'b0, 1'b0, 9};
        tbl[5] = '{8'd0,  8'd3,  8'd0,  8'd0,  1'b1, 1'b0, 1'b0, 9};
`else
        tbl[0] = '{8'd100, 8'd7, 8'd14,  8'd2,  1'b0, 1'b0, 1'b0, 9};
        tbl[1] = '{8'd255, 8'd1, 8'd255, 8'd0,  1'b0, 1'b0, 1'b0, 9};
        tbl[2] = '{8'd5,   8'd10, 8'd0,  8'd5,  1'b1, 1'b0, 1'b0, 9};
        tbl[3] = '{8'd0,   8'd3, 8'd0,   8'd0,  1'b1, 1'b0, 1'b0, 9};
        tbl[4] = '{8'd42,  8'd0, 8'hFF,  8'd42, 1'b0, 1'b1, 1'b0, 1};
        tbl[5] = '{8'd200, 8'd9, 8'd22,  8'd2,  1'b0, 1'b0, 1'b0, 9};
`endif
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_q", 32'(quotient), 0);
        chk("rst_r", 32'(remainder), 0);
        chk("rst_flags", 32'({div_by_zero, zero, overflow}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_op(tbl[i].dd, tbl[i].dv);
            chk($sformatf("tbl%0d_q", i), 32'(g_q), 32'(tbl[i].q));
            chk($sformatf("tbl%0d_r", i), 32'(g_r), 32'(tbl[i].r));
            chk($sformatf("tbl%0d_zero", i), 32'(g_z), 32'(tbl[i].z));
            chk($sformatf("tbl%0d_dbz", i), 32'(g_dz), 32'(tbl[i].dz));
            chk($sformatf("tbl%0d_ovf", i), 32'(g_ov), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_lat", i), 32'(g_lat), 32'(tbl[i].lat));
            chk($sformatf("tbl%0d_busy", i), 32'(g_busy), 32'(tbl[i].lat - 1));
        end

        // second start and operand changes during RUN must be ignored
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd9;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        dividend = 8'd10;
        divisor  = 8'd2;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dividend = 8'd77;
        divisor  = 8'd3;
        pulses = 0;
        cq = '0;
        cr = '0;
        for (int c = 0; c < 15; c++) begin
            if (done) begin pulses++; cq = quotient; cr = remainder; end
            @(posedge clk);
            #1;
        end
        model(8'd200, 8'd9, e_q, e_r, e_ov);
        chk("ign_pulses", 32'(pulses), 1);
        chk("ign_q", 32'(cq), 32'(e_q));
        chk("ign_r", 32'(cr), 32'(e_r));

        // asynchronous reset in RUN cycle 4 of 100/7
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_q", 32'(quotient), 0);
        chk("arst_r", 32'(remainder), 0);
        chk("arst_flags", 32'({div_by_zero, zero, overflow}), 0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
            if (c == 2) rst = 1'b0;
        end
        chk("arst_nodone", 32'(pulses), 0);
        run_op(8'd50, 8'd5);
        model(8'd50, 8'd5, e_q, e_r, e_ov);
        chk("post_rst_q", 32'(g_q), 32'(e_q));
        chk("post_rst_r", 32'(g_r), 32'(e_r));

        for (int n = 0; n < 1000; n++) begin
            dd = 8'($urandom);
            dv = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            run_op(dd, dv);
            model(dd, dv, e_q, e_r, e_ov);
            chk($sformatf("rnd%0d_q %0h/%0h", n, dd, dv), 32'(g_q), 32'(e_q));
            chk($sformatf("rnd%0d_r %0h/%0h", n, dd, dv), 32'(g_r), 32'(e_r));
            chk($sformatf("rnd%0d_flags", n), 32'({g_dz, g_z, g_ov}),
                32'({dv == 0, dv != 0 && e_q == 0, e_ov}));
            chk($sformatf("rnd%0d_lat", n), 32'(g_lat), (dv == 0) ? 1 : 9);
`ifndef SIGNED_DIV_EN
            if (dv != 0) begin
                chk($sformatf("rnd%0d_inv", n), 32'(g_q) * 32'(dv) + 32'(g_r), 32'(dd));
                chk($sformatf("rnd%0d_rlt", n), 32'(g_r < dv), 1);
            end
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
